instr_mem_pipelined: RTL

INSTR_MEM_PIPELINED -- requirements
Module: instr_mem_pipelined

---
 rtl/instr_mem_pipelined.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_pipelined.sv
// Instruction memory: self-fills with INIT_WORD after reset, then serves program loads and
// single-cycle fetches. Define IMEM_PARITY_EN to add per-word even parity checking.
`timescale 1ns/1ps

module instr_mem_pipelined #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] INIT_WORD = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_we,
    input  logic [XLEN-1:0] load_addr,
    input  logic [31:0]     load_data,
    output logic            load_ready,
    output logic            load_err,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_ready,
    output logic            fetch_valid,
    output logic [31:0]     fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    output logic [1:0]      fetch_fault
`ifdef IMEM_PARITY_EN
    ,
    input  logic            load_par_flip,
    output logic            parity_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {StFill, StRun} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic [31:0]     mem_q [DEPTH];
    logic            valid_q;
    logic            err_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [1:0]      fault_q;

    logic            run;
    logic            ld_acc;
    logic            ld_ok;
    logic            fe_acc;
    logic            same_word;
    logic [1:0]      ld_fault;
    logic [1:0]      fe_fault;
    logic [AW-1:0]   ld_idx;
    logic [AW-1:0]   fe_idx;
    logic [31:0]     rd_word;

    // Misaligned wins over out of range.
    function automatic logic [1:0] fault_of(input logic [XLEN-1:0] a);
        if (a[1:0] != 2'b00) begin
            return 2'b01;
        end else if ((a >> (AW + 2)) != '0) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    assign run         = (state_q == StRun);
    assign load_ready  = run;
    assign fetch_ready = run;
    assign ld_fault    = fault_of(load_addr);
    assign fe_fault    = fault_of(fetch_addr);
    assign ld_idx      = load_addr[AW+1:2];
    assign fe_idx      = fetch_addr[AW+1:2];
    assign ld_acc      = load_we && run;
    assign ld_ok       = ld_acc && (ld_fault == 2'b00);
    assign fe_acc      = fetch_req && run;
    assign same_word   = ld_ok && (ld_idx == fe_idx);
    assign rd_word     = same_word ? load_data : mem_q[fe_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StFill) begin
                mem_q[cnt_q] <= INIT_WORD;
            end else if (ld_ok) begin
                mem_q[ld_idx] <= load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= INIT_WORD;
            pc_q    <= '0;
            fault_q <= 2'b00;
        end else begin
            valid_q <= fe_acc;
            err_q   <= ld_acc && (ld_fault != 2'b00);
            case (state_q)
                StFill: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= StRun;
                    end
                end
                StRun:   state_q <= StRun;
                default: state_q <= StFill;
            endcase
            if (fe_acc) begin
                pc_q    <= fetch_addr;
                fault_q <= fe_fault;
                instr_q <= (fe_fault == 2'b00) ? rd_word : INIT_WORD;
            end
        end
    end

    assign fetch_valid = valid_q;
    assign load_err    = err_q;
    assign fetch_instr = instr_q;
    assign fetch_pc    = pc_q;
    assign fetch_fault = fault_q;

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH];
    logic perr_q;
    logic rd_par;

    assign rd_par = same_word ? (^load_data ^ load_par_flip) : par_q[fe_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StFill) begin
                par_q[cnt_q] <= ^INIT_WORD;
            end else if (ld_ok) begin
                par_q[ld_idx] <= ^load_data ^ load_par_flip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (fe_acc) begin
            perr_q <= (fe_fault == 2'b00) && ((^rd_word) != rd_par);
        end
    end

    assign parity_err = perr_q;
`endif

endmodule
